// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared types and constants for the CPU-to-peripheral I/O bridge
package io_bridge_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Load data returned to the CPU when the peripheral never answers
    localparam logic [7:0] RDATA_ERR = 8'hFF;

    // Wait-cycle counter width; covers the full timeout range 1..255
    localparam int CNT_W = 8;

endpackage

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - single-outstanding CPU-to-peripheral read/write bridge with timeout
//
// Accepts one load/store from the CPU while idle, issues a one-cycle read or
// write strobe to the peripheral, waits for the matching ready and reports
// completion (with read data) or a timeout error back to the CPU.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   cpu_req/we/addr/wdata CPU request side (sampled only while idle)
//   cpu_busy              high whenever a transaction is in flight
//   cpu_done/err/rdata    one-cycle completion pulse, error flag, load data
//   read/write            one-cycle peripheral strobes
//   address/data_in       peripheral address and write data (held until next accept)
//   data_out              peripheral read data, valid with ready_r
//   ready_r/ready_w       peripheral read / write acknowledges
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int size_addr = 4,
    parameter int timeout   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [size_addr-1:0] cpu_addr,
    input  logic [7:0]           cpu_wdata,
    output logic                 cpu_busy,
    output logic                 cpu_done,
    output logic                 cpu_err,
    output logic [7:0]           cpu_rdata,
    output logic                 read,
    output logic                 write,
    output logic [size_addr-1:0] address,
    output logic [7:0]           data_in,
    input  logic [7:0]           data_out,
    input  logic                 ready_r,
    input  logic                 ready_w
);

    // Last counter value before giving up; counter starts at 0 on WAIT entry,
    // so the bridge spends exactly 'timeout' cycles in WAIT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout - 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   we_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic [7:0]             rdata_q;
    logic                   read_q;
    logic                   write_q;
    logic [size_addr-1:0]   addr_q;
    logic [7:0]             wdata_q;

    // Only the acknowledge that matches the outstanding direction counts
    logic ready_match;
    assign ready_match = we_q ? ready_w : ready_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        read_q  <= !cpu_we;
                        write_q <= cpu_we;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A ready arriving while the strobe is still up is stale
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Ready is checked before the timeout so a ready on the
                    // final cycle still completes cleanly.
                    if (ready_match) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= data_out;
                        end
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= RDATA_ERR;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_busy  = busy_q;
    assign cpu_done  = done_q;
    assign cpu_err   = err_q;
    assign cpu_rdata = rdata_q;
    assign read      = read_q;
    assign write     = write_q;
    assign address   = addr_q;
    assign data_in   = wdata_q;

endmodule
